arcade_input_mapper: RTL and testbench
======================================

# arcade_input_mapper

Parametrised player-input conditioner between `hps_io` joystick words and an arcade core's control inputs. It generalises the fixed two-player OR-mapping to PLAYERS channels with two modes: shared (all pads OR'd) or per-player. It adds registered outputs, coin pulse shaping with lockout, and optional per-player autofire. It sits in `emu`, clocked by `clk_sys`, feeding the core's start/coin/direction/fire pins.

## Interface
- PLAYERS, 2: number of player channels, 1..4.
- COIN_PULSE, 120000: coin_out high time in clk_sys cycles (10 ms at 12 MHz), ≥1.
- AUTOFIRE_DIV, 600000: autofire half-period in clk_sys cycles, ≥1.

- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- shared_mode  in  1  1 = OR of all pads drives every player; 0 = pad p drives player p.
- joy_in  in  16*PLAYERS  pad p at [16p+15:16p]; bit0 right, 1 left, 2 down, 3 up, 4 fire, 5 start, 6 start-alt, 7 coin.
- autofire_en  in  PLAYERS  per-player autofire enable.
- dir_out  out  4*PLAYERS  player p at [4p+3:4p] = {up,down,left,right}.
- fire_out  out  PLAYERS  conditioned fire.
- start_out  out  PLAYERS  start buttons.
- coin_out  out  PLAYERS  shaped coin pulses.

## Operation
- Source select, per player p: src_p = shared_mode ? OR of all pads : joy_in pad p.
- dir_out and fire (before autofire) come from src_p bits [3:0] and [4].
- start_out, per-player mode: start_out[p] = pad p bit5.
- start_out, shared mode: start_out[0] = OR bit5; start_out[1] = OR bit6; start_out[p≥2] = 0.
- Coin source, per-player mode: coin_src[p] = pad p bit7.
- Coin source, shared mode: coin_src[0] = OR bit7; coin_src[p≥1] = 0.
- Coin FSM per channel, states IDLE, PULSE, GAP:
  - IDLE→PULSE on rising edge of coin_src, i.e. current high and registered previous low. Counter loads, coin_out goes high.
  - PULSE lasts exactly COIN_PULSE cycles, then →GAP with coin_out low.
  - GAP lasts exactly COIN_PULSE cycles, then →IDLE.
  - Rising edges seen in PULSE or GAP are discarded, not queued.
  - A coin held continuously never retriggers; a new edge is required.
- Autofire, per player:
  - Each player has a phase bit and a counter, width $clog2(AUTOFIRE_DIV).
  - Rising edge of fire: phase←1, counter←0.
  - While fire is held: counter wraps at AUTOFIRE_DIV−1 and toggles phase on wrap.
  - Fire released: phase←0, counter←0.
  - fire_out = fire & (autofire_en[p] ? phase : 1).
- Changing shared_mode takes effect on the next edge. Coin FSMs keep their state. The edge detector compares against the previously registered value of the newly selected source.

## Timing
- All outputs are registered. Latency is 1 cycle from joy_in / autofire_en / shared_mode to dir_out, start_out and fire_out.
- coin_out rises on the edge that samples the coin rising edge, i.e. 1 cycle after joy_in changes. It stays high exactly COIN_PULSE cycles.
- Minimum coin-to-coin spacing: 2*COIN_PULSE cycles.
- Reset values:
  - All outputs 0; FSMs IDLE; counters 0; phase 0.
  - Coin previous-value registers are set to 1, so a coin held through reset does not fire on release.
- Reset asserted mid-pulse: coin_out is 0 at the next edge and the pulse is aborted.
- Simultaneous reset and input edge: reset wins.
- PLAYERS=1 with shared_mode: start_out[0] = OR bit5 only; bit6 is ignored.

## Configuration
- INPUT_AUTOFIRE_EN defined: autofire counters and phase logic are built as above.
- INPUT_AUTOFIRE_EN undefined:
  - No autofire registers exist.
  - autofire_en is ignored.
  - fire_out = registered src_p bit4.
  - The port list is unchanged.

## Test plan
- Reset release with pad0 bit7 held high (PLAYERS=2, COIN_PULSE=4) -> coin_out stays 0. Release bit7, then reassert -> coin_out[0] high exactly 4 cycles, starting 1 cycle after the edge.
- Coin pulse, COIN_PULSE=4: second rising edge 3 cycles after the first, and again 6 cycles after -> both ignored. Edge at cycle 9 -> second pulse produced.
- shared_mode=1, pad1=16'h0011 -> both players: dir_out nibble 4'b0001, fire_out 1. Then shared_mode=0 -> player0 outputs all 0 next cycle, player1 unchanged.
- shared_mode=1, pad0 bit6 and pad1 bit5 high -> start_out=2'b11. shared_mode=0 -> start_out=2'b10.
- INPUT_AUTOFIRE_EN, AUTOFIRE_DIV=3, autofire_en[0]=1, fire held 12 cycles -> fire_out[0] pattern 1,1,1,0,0,0,1,1,1,0,0,0. Release -> 0 next cycle. autofire_en=0 -> steady 1.
- Reset pulsed at cycle 2 of a 4-cycle coin pulse -> coin_out 0 the next cycle. Fresh edge after reset -> full 4-cycle pulse.

Source files
------------

// File: rtl/arcade_input_mapper_if.sv
// arcade_input_mapper_if: joystick words in, conditioned core control pins out
interface arcade_input_mapper_if #(
    parameter int PLAYERS = 2
);
    logic                   shared_mode;
    logic [16*PLAYERS-1:0]  joy_in;
    logic [PLAYERS-1:0]     autofire_en;
    logic [4*PLAYERS-1:0]   dir_out;
    logic [PLAYERS-1:0]     fire_out;
    logic [PLAYERS-1:0]     start_out;
    logic [PLAYERS-1:0]     coin_out;
    modport master (
        output shared_mode, joy_in, autofire_en,
        input  dir_out, fire_out, start_out, coin_out
    );
    modport slave (
        input  shared_mode, joy_in, autofire_en,
        output dir_out, fire_out, start_out, coin_out
    );
endinterface

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: shared/per-player pad mapping, coin pulse shaping with lockout,
// and per-player autofire when INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper #(
    parameter int PLAYERS      = 2,
    parameter int COIN_PULSE   = 120000,
    parameter int AUTOFIRE_DIV = 600000
) (
    input logic clk_sys,
    input logic reset,
    arcade_input_mapper_if.slave io
);
    localparam int CW = COIN_PULSE > 1 ? $clog2(COIN_PULSE) : 1;
    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;
    logic [7:0]         pad_or;
    logic [7:0]         src [PLAYERS];
    logic [PLAYERS-1:0] coin_q, coin_src, coin_rise, start_src, fire_src, fire_n;
    coin_state_t        st [PLAYERS];
    coin_state_t        st_n [PLAYERS];
    logic [CW-1:0]      cnt [PLAYERS];
    logic [CW-1:0]      cnt_n [PLAYERS];
    // coin_q holds raw pad bit7s so the previous value of whichever source is now selected can be rebuilt
    always_comb begin
        pad_or = '0;
        for (int p = 0; p < PLAYERS; p++) pad_or |= io.joy_in[16*p +: 8];
        for (int p = 0; p < PLAYERS; p++) begin
            src[p]       = io.shared_mode ? pad_or : io.joy_in[16*p +: 8];
            start_src[p] = io.shared_mode ? (p == 0 ? src[p][5] : p == 1 ? src[p][6] : 1'b0) : src[p][5];
            coin_src[p]  = io.shared_mode ? (p == 0 && src[p][7]) : src[p][7];
            coin_rise[p] = coin_src[p] & ~(io.shared_mode ? (p == 0 && |coin_q) : coin_q[p]);
            fire_src[p]  = src[p][4];
        end
    end
    always_comb begin
        io.coin_out = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            st_n[p]        = (st[p] == IDLE) ? (coin_rise[p] ? PULSE : IDLE)
                           : (cnt[p] != CW'(COIN_PULSE - 1)) ? st[p]
                           : (st[p] == PULSE) ? GAP : IDLE;
            cnt_n[p]       = (st[p] == IDLE || cnt[p] == CW'(COIN_PULSE - 1)) ? '0 : cnt[p] + 1'b1;
            io.coin_out[p] = st[p] == PULSE;
        end
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            io.dir_out   <= '0;
            io.fire_out  <= '0;
            io.start_out <= '0;
            coin_q       <= '1;
            for (int p = 0; p < PLAYERS; p++) begin
                st[p]  <= IDLE;
                cnt[p] <= '0;
            end
        end else begin
            io.fire_out  <= fire_n;
            io.start_out <= start_src;
            for (int p = 0; p < PLAYERS; p++) begin
                io.dir_out[4*p +: 4] <= src[p][3:0];
                coin_q[p]            <= io.joy_in[16*p + 7];
                st[p]                <= st_n[p];
                cnt[p]               <= cnt_n[p];
            end
        end
    end
`ifdef INPUT_AUTOFIRE_EN
    localparam int AW = AUTOFIRE_DIV > 1 ? $clog2(AUTOFIRE_DIV) : 1;
    logic [PLAYERS-1:0] fire_q, phase, phase_n;
    logic [AW-1:0]      af_cnt [PLAYERS];
    logic [AW-1:0]      af_cnt_n [PLAYERS];
    // fire_out uses the phase being loaded this edge, so a fresh press fires immediately
    always_comb begin
        phase_n = '0;
        fire_n  = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            phase_n[p]  = !fire_src[p] ? 1'b0
                        : !fire_q[p] ? 1'b1
                        : (af_cnt[p] == AW'(AUTOFIRE_DIV - 1)) ? ~phase[p] : phase[p];
            af_cnt_n[p] = (!fire_src[p] || !fire_q[p] || af_cnt[p] == AW'(AUTOFIRE_DIV - 1)) ? '0 : af_cnt[p] + 1'b1;
            fire_n[p]   = fire_src[p] & (io.autofire_en[p] ? phase_n[p] : 1'b1);
        end
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            fire_q <= '0;
            phase  <= '0;
            for (int p = 0; p < PLAYERS; p++) af_cnt[p] <= '0;
        end else begin
            fire_q <= fire_src;
            phase  <= phase_n;
            for (int p = 0; p < PLAYERS; p++) af_cnt[p] <= af_cnt_n[p];
        end
    end
`else
    assign fire_n = fire_src;
`endif
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed literal checks plus randomized run against a behavioural model
module tb_arcade_input_mapper;
    localparam int NP = 2;
    localparam int CP = 4;
    localparam int AD = 3;
    logic clk_sys = 1'b0;
    logic reset;
    logic chk = 1'b0;
    int   checks = 0;
    int   errors = 0;
    arcade_input_mapper_if #(.PLAYERS(NP)) io ();
    arcade_input_mapper #(.PLAYERS(NP), .COIN_PULSE(CP), .AUTOFIRE_DIV(AD)) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .io(io)
    );
    always #5 clk_sys = ~clk_sys;
    // model state: coin age counts cycles since an accepted coin edge (-1 = ready for a coin)
    logic [7:0]  e_dir;
    logic [1:0]  e_fire, e_start, e_coin;
    int          age [NP];
    int          held [NP];
    logic [NP-1:0] prev7, pfire;
    logic [15:0] m_or, m_s;
    logic        m_csrc, m_cprev, m_f;
    always @(posedge clk_sys) begin
        m_or = '0;
        for (int p = 0; p < NP; p++) m_or = m_or | io.joy_in[16*p +: 16];
        if (reset) begin
            e_dir = '0;
            e_fire = '0;
            e_start = '0;
            e_coin = '0;
            prev7 = '1;
            pfire = '0;
            for (int p = 0; p < NP; p++) begin
                age[p] = -1;
                held[p] = 0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                m_s = io.shared_mode ? m_or : io.joy_in[16*p +: 16];
                e_dir[4*p +: 4] = m_s[3:0];
                e_start[p] = io.shared_mode ? (p == 0 ? m_or[5] : (p == 1 ? m_or[6] : 1'b0)) : m_s[5];
                m_csrc = io.shared_mode ? (p == 0 && m_or[7]) : m_s[7];
                m_cprev = io.shared_mode ? (p == 0 && (|prev7)) : prev7[p];
                if (age[p] < 0) begin
                    if (m_csrc && !m_cprev) age[p] = 0;
                end else begin
                    age[p] = age[p] + 1;
                    if (age[p] >= 2*CP) age[p] = -1;
                end
                e_coin[p] = (age[p] >= 0) && (age[p] < CP);
                m_f = m_s[4];
`ifdef INPUT_AUTOFIRE_EN
                held[p] = (m_f && pfire[p]) ? held[p] + 1 : 0;
                e_fire[p] = m_f && (!io.autofire_en[p] || ((held[p] / AD) % 2 == 0));
`else
                e_fire[p] = m_f;
`endif
                pfire[p] = m_f;
            end
            for (int p = 0; p < NP; p++) prev7[p] = io.joy_in[16*p + 7];
        end
    end
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask
    always @(negedge clk_sys) begin
        if (chk) begin
            check("model dir_out", io.dir_out, e_dir);
            check("model fire_out", io.fire_out, e_fire);
            check("model start_out", io.start_out, e_start);
            check("model coin_out", io.coin_out, e_coin);
        end
    end
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #2;
        end
    endtask
    int seq7 [13] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1};
    int want7 [13] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
`ifdef INPUT_AUTOFIRE_EN
    int af_pat [12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
`else
    int af_pat [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    logic [31:0] j;
    initial begin
        reset = 1'b1;
        io.shared_mode = 1'b0;
        io.autofire_en = '0;
        io.joy_in = 32'h0000_0080;
        cyc(1);
        chk = 1'b1;
        check("reset coin", io.coin_out, 0);
        check("reset dir", io.dir_out, 0);
        cyc(2);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            check("coin held through reset", io.coin_out, 0);
        end
        io.joy_in = '0;
        cyc(1);
        io.joy_in = 32'h0000_0080;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            check("first coin pulse", io.coin_out, (k < 4) ? 1 : 0);
        end
        io.joy_in = '0;
        cyc(10);
        for (int k = 0; k < 13; k++) begin
            io.joy_in = (seq7[k] != 0) ? 32'h0000_0080 : 32'h0;
            cyc(1);
            check("coin lockout", io.coin_out, want7[k]);
        end
        io.joy_in = '0;
        cyc(10);
        io.shared_mode = 1'b1;
        io.joy_in = 32'h0011_0000;
        cyc(1);
        check("shared dir", io.dir_out, 32'h11);
        check("shared fire", io.fire_out, 32'h3);
        io.shared_mode = 1'b0;
        cyc(1);
        check("per-player dir", io.dir_out, 32'h10);
        check("per-player fire", io.fire_out, 32'h2);
        io.shared_mode = 1'b1;
        io.joy_in = 32'h0020_0040;
        cyc(1);
        check("shared start", io.start_out, 32'h3);
        io.shared_mode = 1'b0;
        cyc(1);
        check("per-player start", io.start_out, 32'h2);
        io.joy_in = '0;
        io.autofire_en = 2'b01;
        cyc(1);
        io.joy_in = 32'h0000_0010;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            check("autofire pattern", io.fire_out[0], af_pat[k]);
        end
        io.joy_in = '0;
        cyc(1);
        check("autofire release", io.fire_out[0], 0);
        io.autofire_en = '0;
        io.joy_in = 32'h0000_0010;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            check("autofire off steady", io.fire_out[0], 1);
        end
        io.joy_in = '0;
        cyc(10);
        io.joy_in = 32'h0000_0080;
        cyc(1);
        check("pulse before reset", io.coin_out, 1);
        cyc(1);
        check("pulse before reset", io.coin_out, 1);
        reset = 1'b1;
        cyc(1);
        check("reset aborts pulse", io.coin_out, 0);
        reset = 1'b0;
        cyc(2);
        check("held coin after reset", io.coin_out, 0);
        io.joy_in = '0;
        cyc(1);
        io.joy_in = 32'h0000_0080;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            check("pulse after reset", io.coin_out, (k < 4) ? 1 : 0);
        end
        j = '0;
        for (int i = 0; i < 3000; i++) begin
            j = j ^ ($urandom & $urandom & $urandom);
            io.joy_in = j;
            if ($urandom_range(0, 31) == 0) io.shared_mode = ~io.shared_mode;
            if ($urandom_range(0, 15) == 0) io.autofire_en = 2'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            cyc(1);
        end
        reset = 1'b0;
        cyc(2);
        chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
